// File: rtl/disp_arbiter.sv
// Three-requester display arbiter: strict priority with a minimum grant hold time.
// Optional blinking of the alarm display is enabled with macro DISP_ARB_BLINK_EN.
`timescale 1ns/1ps
module disp_arbiter #(
  parameter int unsigned HOLD_CYC  = 50_000_000,
  parameter int unsigned BLINK_CYC = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  gnt,
  output logic [15:0] disp_data,
  output logic        busy,
  output logic        sw
);

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYC - 1);

  if (HOLD_CYC < 2 || BLINK_CYC < 1) begin : g_param_check
    $error("disp_arbiter: HOLD_CYC must be >= 2 and BLINK_CYC >= 1");
  end

  state_t      state, state_nxt;
  logic [31:0] hold_cnt, hold_cnt_nxt;
  logic [2:0]  gnt_nxt;
  logic [15:0] disp_nxt;
  logic        sw_nxt;
  logic        take, load, own;
  logic [2:0]  top, higher;

`ifdef DISP_ARB_BLINK_EN
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYC - 1);
  logic [31:0] blink_cnt, blink_cnt_nxt;
  logic        blink_vis, blink_vis_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt;
    disp_nxt     = disp_data;
    sw_nxt       = 1'b0;
    take         = 1'b0;
    load         = 1'b0;
    top          = req & (~req + 3'd1);
    own          = |(req & gnt);
    higher       = req & (gnt - 3'd1);

    case (state)
      IDLE: take = |req;
      HOLD: begin
        if (req[0] && gnt != 3'b001) begin
          take = 1'b1;
        end else begin
          load = own;
          if (hold_cnt == '0) state_nxt = OPEN;
          else                hold_cnt_nxt = hold_cnt - 32'd1;
        end
      end
      OPEN: begin
        if (own && higher == '0) begin
          load = 1'b1;
        end else if (|req) begin
          take = 1'b1;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          disp_nxt  = '1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take) begin
      gnt_nxt      = top;
      state_nxt    = HOLD;
      hold_cnt_nxt = HOLD_LOAD;
      sw_nxt       = 1'b1;
      load         = 1'b1;
    end

`ifdef DISP_ARB_BLINK_EN
    // Blink phase restarts visible on every new grant to the alarm requester.
    blink_cnt_nxt = blink_cnt;
    blink_vis_nxt = blink_vis;
    if (take && gnt_nxt == 3'b001) begin
      blink_cnt_nxt = '0;
      blink_vis_nxt = 1'b1;
    end else if (gnt == 3'b001 && gnt_nxt == 3'b001) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt = '0;
        blink_vis_nxt = ~blink_vis;
      end else begin
        blink_cnt_nxt = blink_cnt + 32'd1;
      end
    end
`endif

    if (load) begin
      case (gnt_nxt)
`ifdef DISP_ARB_BLINK_EN
        3'b001:  disp_nxt = blink_vis_nxt ? data0 : '1;
`else
        3'b001:  disp_nxt = data0;
`endif
        3'b010:  disp_nxt = data1;
        3'b100:  disp_nxt = data2;
        default: disp_nxt = disp_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      gnt       <= '0;
      disp_data <= '1;
      sw        <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      gnt       <= gnt_nxt;
      disp_data <= disp_nxt;
      sw        <= sw_nxt;
    end
  end

`ifdef DISP_ARB_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_vis <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_vis <= blink_vis_nxt;
    end
  end
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter (HOLD_CYC=4, BLINK_CYC=2): directed cases
// followed by random traffic, checked against an elapsed-time reference model.
`timescale 1ns/1ps
module tb_disp_arbiter;

  localparam int unsigned H = 4;
  localparam int unsigned B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [2:0]  gnt;
  logic [15:0] disp_data;
  logic        busy, sw;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current grant index (-1 none), cycles since grant,
  // cycles since grant to requester 0, expected display and switch pulse.
  int          m_g;
  int unsigned m_el;
  int unsigned m_bl;
  logic [15:0] m_disp;
  logic        m_sw;

  logic [15:0] exp30 [6];

  disp_arbiter #(.HOLD_CYC(4), .BLINK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .gnt(gnt), .disp_data(disp_data), .busy(busy), .sw(sw)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $fatal(1, "FAIL timeout: bench did not finish");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] shown(input int g, input logic [15:0] v);
`ifdef DISP_ARB_BLINK_EN
    if (g == 0) return (((m_bl / B) % 2) == 0) ? v : 16'hFFFF;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_g = -1; m_el = 0; m_bl = 0; m_disp = 16'hFFFF; m_sw = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] d [3];
    int hi;
    bit own, newg, to_idle;
    if (!rst_n) return;
    d[0] = data0; d[1] = data1; d[2] = data2;
    hi = -1;
    for (int i = 2; i >= 0; i--) if (req[i]) hi = i;
    own = (m_g >= 0) && req[m_g];
    newg = 1'b0; to_idle = 1'b0;
    if (m_g < 0)         newg = (hi >= 0);
    else if (m_el < H)   newg = req[0] && (m_g != 0);
    else if (!(own && hi == m_g)) begin
      if (hi >= 0) newg = 1'b1;
      else         to_idle = 1'b1;
    end
    m_sw = newg;
    if (newg) begin
      m_g = hi; m_el = 0;
      if (hi == 0) m_bl = 0;
      m_disp = shown(hi, d[hi]);
    end else if (to_idle) begin
      m_g = -1; m_disp = 16'hFFFF;
    end else if (m_g >= 0) begin
      if (m_el < H) m_el++;
      if (m_g == 0) m_bl++;
      if (own) m_disp = shown(m_g, d[m_g]);
    end
  endtask

  task automatic check_all();
    logic [2:0] eg;
    eg = (m_g < 0) ? 3'b000 : 3'(3'b001 << m_g);
    check("gnt",    {13'b0, gnt}, {13'b0, eg});
    check("disp",   disp_data, m_disp);
    check("sw",     {15'b0, sw}, {15'b0, m_sw});
    check("busy",   {15'b0, busy}, {15'b0, (m_g >= 0)});
    check("onehot", {15'b0, ($countones(gnt) <= 1)}, 16'd1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_g >= 0; i++) tick();
    check("idle_reached", {15'b0, busy}, 16'd0);
  endtask

  initial begin
`ifdef DISP_ARB_BLINK_EN
    exp30 = '{16'h0911, 16'h0911, 16'hFFFF, 16'hFFFF, 16'h0911, 16'h0911};
`else
    exp30 = '{16'h0911, 16'h0911, 16'h0911, 16'h0911, 16'h0911, 16'h0911};
`endif
    rst_n = 1'b1; req = 3'b000;
    data0 = 16'($urandom); data1 = 16'($urandom); data2 = 16'($urandom);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;

    // Idle request from requester 1
    data1 = 16'h1234; req = 3'b010;
    tick();
    check("r26_gnt",  {13'b0, gnt}, 16'h0002);
    check("r26_disp", disp_data, 16'h1234);
    check("r26_sw",   {15'b0, sw}, 16'd1);
    check("r26_busy", {15'b0, busy}, 16'd1);
    tick();
    check("r26_sw_once", {15'b0, sw}, 16'd0);

    // Lower priority arrival during HOLD waits for requester 1 to release
    req = 3'b110;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r27_keep", {13'b0, gnt}, 16'h0002);
    end
    req = 3'b100;
    tick();
    check("r27_switch", {13'b0, gnt}, 16'h0004);

    // Alarm preempts during HOLD and restarts the hold time
    tick();
    data0 = 16'($urandom); req = 3'b101;
    tick();
    check("r28_gnt",  {13'b0, gnt}, 16'h0001);
    check("r28_disp", disp_data, data0);
    check("r28_sw",   {15'b0, sw}, 16'd1);
    req = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r28_reload", {13'b0, gnt}, 16'h0001);
    end
    tick();
    check("r28_after", {13'b0, gnt}, 16'h0004);

    // Release with no other request: full hold, then IDLE
    req = 3'b000;
    wait_idle();
    data1 = 16'($urandom); req = 3'b010;
    tick();
    req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r29_held", {13'b0, gnt}, 16'h0002);
    end
    tick();
    check("r29_gnt",  {13'b0, gnt}, 16'h0000);
    check("r29_disp", disp_data, 16'hFFFF);
    check("r29_busy", {15'b0, busy}, 16'd0);

    // Alarm display pattern (blinking or steady depending on build)
    data0 = 16'h0911; req = 3'b001;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("r30_disp", disp_data, exp30[i]);
    end
    req = 3'b000;
    wait_idle();

    // Asynchronous reset mid-HOLD, request still present after release
    req = 3'b100;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("r31_gnt",  {13'b0, gnt}, 16'h0000);
    check("r31_disp", disp_data, 16'hFFFF);
    check("r31_busy", {15'b0, busy}, 16'd0);
    check("r31_sw",   {15'b0, sw}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("r31_regrant", {13'b0, gnt}, 16'h0004);
    check("r31_sw1",     {15'b0, sw}, 16'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 15) == 0) req = 3'b000;
      data0 = 16'($urandom); data1 = 16'($urandom); data2 = 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 50_000_000, meaning the minimum clk cycles a grant is held before it can be re-arbitrated (legal range 2..2^32-1).
REQ-002 The block SHALL have parameter BLINK_CYC, default 25_000_000, meaning the clk cycles per blink half-period (legal range 1..2^32-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req, input, 3 bits: display requests; bit 0 is alarm (highest priority), bit 1 is password entry, bit 2 is idle/status (lowest).
REQ-006 The block SHALL have ports data0, data1, data2, each input, 16 bits: four BCD digits per requester, nibble [3:0] being the rightmost digit.
REQ-007 The block SHALL have port gnt, output, 3 bits: one-hot grant, or all zero when no requester is granted.
REQ-008 The block SHALL have port disp_data, output, 16 bits: registered word driving the 4-digit display; nibble 4'hF renders a blank digit.
REQ-009 The block SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-010 The block SHALL have port sw, output, 1 bit: a one-cycle pulse on every cycle in which gnt changes to a new non-zero value.

Function
REQ-011 The FSM SHALL have states IDLE (no grant), HOLD (grant locked, hold counter running) and OPEN (hold expired, grant re-arbitrable).
REQ-012 In IDLE with req!=0, the block SHALL, on the next edge, grant the highest-priority asserted requester, load the hold counter with HOLD_CYC-1, enter HOLD, pulse sw and load disp_data from the granted requester's data in that same edge.
REQ-013 In HOLD, the hold counter SHALL decrement once per cycle and the FSM SHALL enter OPEN on the edge at which the counter is 0, so the grant is held exactly HOLD_CYC cycles.
REQ-014 In HOLD, req[0] asserted while gnt!=3'b001 SHALL preempt at the next edge: gnt becomes 3'b001, the counter reloads, the FSM stays in HOLD and sw pulses; req[1] and req[2] SHALL NOT preempt during HOLD.
REQ-015 While the granted requester's req bit is high, disp_data SHALL reload from that requester's data every cycle (one-cycle latency); while that bit is low during HOLD, disp_data SHALL hold its last value.
REQ-016 In OPEN, if a higher-priority req is asserted, the block SHALL switch to it, reload the counter, enter HOLD and pulse sw.
REQ-017 In OPEN, if the granted req is still high and no higher-priority req is asserted, the block SHALL keep the grant and stay in OPEN (strict priority; lower-priority requesters wait).
REQ-018 In OPEN, if the granted req is low and another req is high, the block SHALL grant the highest-priority asserted requester and enter HOLD.
REQ-019 In OPEN, if the granted req is low and req==0, the block SHALL go to IDLE with gnt=0 and disp_data=16'hFFFF.
REQ-020 When the release of the granted requester and the arrival of a new request occur in the same cycle, the new request SHALL be granted directly, without passing through IDLE.
REQ-021 gnt SHALL be one-hot or zero at all times.

Reset
REQ-022 Assertion of rst_n=0 SHALL, immediately and regardless of state, force state=IDLE, gnt=3'b000, disp_data=16'hFFFF, busy=0, sw=0, and clear the hold and blink counters.
REQ-023 Reset released mid-grant SHALL resume from IDLE; a request still asserted SHALL be granted per REQ-012 at the first edge after release.

Configuration
REQ-024 With macro DISP_ARB_BLINK_EN defined, the block SHALL, while gnt=3'b001, alternate disp_data between data0 (visible phase, starting at grant) and 16'hFFFF every BLINK_CYC cycles; the blink counter SHALL restart at each grant to requester 0.
REQ-025 With DISP_ARB_BLINK_EN undefined, no blink logic SHALL exist and data0 SHALL be displayed steadily while requester 0 is granted.

Verification (HOLD_CYC=4, BLINK_CYC=2)
REQ-026 The bench SHALL cover: reset, then req=3'b010 with data1=16'h1234 -> next edge gnt=3'b010, disp_data=16'h1234, sw=1 for one cycle, busy=1.
REQ-027 The bench SHALL cover: requester 1 granted, req[2] raised at cycle 1 of HOLD -> gnt stays 3'b010 until req[1] drops after hold, then gnt=3'b100.
REQ-028 The bench SHALL cover: requester 2 granted, req[0] raised in HOLD -> next edge gnt=3'b001, disp_data=data0, counter reloaded.
REQ-029 The bench SHALL cover: requester 1 granted, req dropped to 0 -> grant held 4 cycles total, then IDLE, gnt=0, disp_data=16'hFFFF.
REQ-030 The bench SHALL cover: with DISP_ARB_BLINK_EN defined, requester 0 granted with data0=16'h0911 -> disp_data sequence 0911,0911,FFFF,FFFF,0911...; with the macro undefined -> steady 16'h0911.
REQ-031 The bench SHALL cover: rst_n pulsed low mid-HOLD -> outputs take reset values asynchronously; with req=3'b100 still high -> gnt=3'b100 at the first edge after release.
